// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler sharing one T flip-flop toggle enable among NUM_REQ requesters.
// Each grant emits a burst of single-cycle t_out pulses separated by SPACING idle cycles.
module tff_toggle_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int SPACING = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
  output logic                     t_out,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int OW    = $clog2(NUM_REQ);
  // Keep the gap counter at least one bit wide so SPACING=0 still elaborates.
  localparam int GAP_W = (SPACING > 0) ? $clog2(SPACING + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [OW-1:0]      pick;
  logic               found;
  logic [CNT_W-1:0]   pick_cnt;

  // First pending requester above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign pick_cnt = req_cnt[int'(pick)*CNT_W +: CNT_W];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          rem_d   = pick_cnt;
          state_d = (pick_cnt != '0) ? PULSE : DONE;
        end
      end
      PULSE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end
        if (rem_q <= CNT_W'(1)) begin
          state_d = DONE;
        end else if (SPACING == 0) begin
          state_d = PULSE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_W'(SPACING - 1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = PULSE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE: begin
        rr_ptr_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= OW'(NUM_REQ - 1);
      rem_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
    end
  end

  // Outputs decode straight from registered state and owner.
  assign t_out = (state_q == PULSE);
  assign busy  = (state_q != IDLE);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign grant[gi] = (state_q != IDLE) && (owner_q == OW'(gi));
      assign done[gi]  = (state_q == DONE) && (owner_q == OW'(gi));
    end
  endgenerate

endmodule

// File: doc/tff_toggle_scheduler.md
Name: tff_toggle_scheduler

Overview:
Round-robin scheduler that shares one T flip-flop toggle input between NUM_REQ requesters. Each requester asks for a burst of N toggles. The scheduler grants one requester at a time and emits N single-cycle toggle-enable pulses, spaced by SPACING idle cycles. It then signals completion. It sits between the requester logic and the T flip-flop's toggle input (tin) in the same top-level tile.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 4, width of each requested toggle count
SPACING, 1, idle cycles inserted between consecutive toggle pulses (0 = back-to-back)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
req  input  NUM_REQ  request level per requester
req_cnt  input  NUM_REQ*CNT_W  toggle count per requester; slice i = req_cnt[i*CNT_W +: CNT_W]; sampled only at grant
t_out  output  1  toggle enable to the T flip-flop; one-cycle pulses
grant  output  NUM_REQ  one-hot current owner; all-zero when idle
done  output  NUM_REQ  one-cycle completion pulse to the owner
busy  output  1  high in any state except IDLE

Behaviour:
- Ownership: one clock; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, t_out=0, grant=0, done=0, busy=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority. Remaining count=0, gap count=0.
- All outputs are registered or decoded directly from state registers. There is no combinational path from req to any output.
- States: IDLE, PULSE, GAP, DONE.
- IDLE:
  - If any req bit is high at edge k, choose owner = first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Latch rem = req_cnt slice of owner.
  - Set grant one-hot from cycle k+1.
  - Next state is PULSE if rem != 0, else DONE.
- PULSE:
  - t_out=1 for exactly this one cycle; rem decrements.
  - If rem becomes 0, go to DONE.
  - Otherwise go to GAP, or back to PULSE if SPACING=0.
- GAP:
  - t_out=0 for exactly SPACING cycles, counted with a gap counter of width clog2(SPACING+1).
  - Then go to PULSE.
- DONE:
  - done[owner]=1 for one cycle; grant still held this cycle.
  - rr_ptr <= owner; next state IDLE, where grant returns to 0.
- Timing:
  - First pulse appears the cycle after req is sampled.
  - A count of N takes 1 + N + (N-1)*SPACING + 1 cycles from sampling to the IDLE return.
  - The minimum turnaround between bursts is 1 IDLE cycle.
- Committed requests:
  - Once granted, a burst always completes, even if req drops.
  - Changes to req_cnt after grant are ignored.
- req still high after done: the requester is re-arbitrated normally. Round robin serves every other pending requester before it.
- req_cnt = 0: grant for one cycle in DONE, done pulse, no t_out pulse.
- Count arithmetic:
  - rem is CNT_W bits; the maximum burst is 2^CNT_W - 1 pulses.
  - No wrap can occur, because decrement happens only when rem != 0.
- Reset mid-burst: the next cycle shows all outputs at their reset values. Pulses are truncated and no done is issued. The T flip-flop state is not the scheduler's concern.
- Simultaneous requests in IDLE: exactly one grant, chosen by round robin. The others wait; they are not lost while req stays high.

Test Plan:
- Single request, NUM_REQ=4, SPACING=1: req[2]=1, cnt=3 at edge 0.
  - Required: grant=0100 for cycles 1-6.
  - t_out high at cycles 1, 3, 5.
  - done[2] at cycle 6; busy falls at cycle 7.
  - A T flip-flop starting at q=0 ends at q=1.
- All four requesting continuously, cnt=1 each, from reset.
  - Grant order must be 0, 1, 2, 3, 0, …
  - Each burst lasts 3 cycles with 1 IDLE cycle between bursts.
  - Exactly one t_out pulse per grant.
- Zero count: req[1]=1, cnt=0.
  - Grant=0010 and done[1] in the same single cycle; t_out never asserts.
- Request drop and count change: req[0] drops and req_cnt changes after grant, cnt=5, SPACING=0.
  - Still exactly 5 back-to-back pulses, then done[0].
- Reset mid-burst: rst=1 during the 2nd pulse of cnt=4.
  - Next cycle: t_out=0, grant=0, busy=0, no done.
  - After release, requester 0 wins first.
- Maximum count: CNT_W=4, cnt=15, SPACING=2.
  - 15 pulses, each separated by exactly 2 low cycles.
  - done asserts once; rem ends at 0 with no wrap.
